// File: rtl/booth_mult_param_if.sv
// Handshake/operand bundle for the radix-2 Booth multiplier.
// The master drives the request and operands; the slave (multiplier) returns status and product.
interface booth_mult_param_if #(
    parameter int unsigned DW = 16
);
    logic                sync_clr;
    logic                start;
    logic                signed_mode;
    logic [DW-1:0]       multiplicand;
    logic [DW-1:0]       multiplier;
    logic                busy;
    logic                ready;
    logic [2*DW-1:0]     result;

    modport master (
        output sync_clr,
        output start,
        output signed_mode,
        output multiplicand,
        output multiplier,
        input  busy,
        input  ready,
        input  result
    );

    modport slave (
        input  sync_clr,
        input  start,
        input  signed_mode,
        input  multiplicand,
        input  multiplier,
        output busy,
        output ready,
        output result
    );
endinterface

// File: rtl/booth_mult_param.sv
// Sequential radix-2 Booth multiplier, signed or unsigned operands, fixed latency of DW+2 cycles
// from accepted start to the one-cycle ready pulse.
module booth_mult_param #(
    parameter int unsigned DW = 16
) (
    input logic               clk,
    input logic               rst,
    booth_mult_param_if.slave bus
);
    localparam int unsigned PW  = 2 * DW;
    localparam int unsigned UW  = DW + 2;  // accumulator half, wide enough for A = most-negative
    localparam int unsigned LW  = DW + 2;  // extended multiplier plus Booth guard bit
    localparam int unsigned PBW = UW + LW;
    localparam int unsigned CW  = $clog2(DW + 2);
    localparam logic [CW-1:0] LastCnt = CW'(DW + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [DW:0]      a_q;
    logic [PBW-1:0]   p_q;
    logic [CW-1:0]    cnt_q;
    logic [PW-1:0]    result_q;

    logic [DW:0]      a_in;
    logic [DW:0]      b_in;
    logic [UW-1:0]    a_ext;
    logic [UW-1:0]    upper;
    logic [UW-1:0]    sum;
    logic [PBW-1:0]   p_step;
    logic             accept;
    logic             finish;

    // Operand extension to DW+1 bits lets one signed Booth engine serve both modes.
    always_comb begin
        a_in = bus.signed_mode ? {bus.multiplicand[DW-1], bus.multiplicand}
                               : {1'b0, bus.multiplicand};
        b_in = bus.signed_mode ? {bus.multiplier[DW-1], bus.multiplier}
                               : {1'b0, bus.multiplier};
    end

    always_comb begin
        a_ext = {a_q[DW], a_q};
        upper = p_q[PBW-1 -: UW];
        sum   = upper;
        case (p_q[1:0])
            2'b01:   sum = upper + a_ext;
            2'b10:   sum = upper - a_ext;
            default: sum = upper;
        endcase
        p_step = {sum[UW-1], sum, p_q[LW-1:1]};
    end

    always_comb begin
        accept = (state_q == StIdle) && bus.start && !bus.sync_clr;
        finish = (state_q == StRun) && (cnt_q == LastCnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.sync_clr) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (bus.start) state_d = StRun;
                StRun:   if (cnt_q == LastCnt) state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        bus.busy   = (state_q == StRun) || (state_q == StDone);
        bus.ready  = (state_q == StDone);
        bus.result = result_q;
    end

    // After DW+1 steps {upper, multiplier field} holds the full product; the guard bit is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (bus.sync_clr) begin
            cnt_q <= '0;
        end else if (accept) begin
            a_q   <= a_in;
            p_q   <= {{UW{1'b0}}, b_in, 1'b0};
            cnt_q <= '0;
        end else if (finish) begin
            result_q <= p_q[PW:1];
        end else if (state_q == StRun) begin
            p_q   <= p_step;
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: tb/tb_booth_mult_param.sv
// Bench for booth_mult_param: directed DW=16 scenarios against a latency/product model,
// plus parallel random lanes at DW=16 and DW=8.
module tb_booth_mult_param;
    localparam int unsigned DW = 16;
    localparam int PH_DONE = DW + 3;
    localparam int NL16 = 5;
    localparam int NL8 = 4;
    localparam int NL = NL16 + NL8;
    localparam int NOPS16 = 2000;
    localparam int NOPS8 = 2500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_r = 1'b1;
    bit   cmp_en = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    int   lanes_done = 0;

    always #5 clk = ~clk;

    initial begin
        #23 rst_r = 1'b0;
    end

    booth_mult_param_if #(.DW(DW)) bus ();
    booth_mult_param #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // Exact product of dw-bit operands, truncated to 2*dw bits.
    function automatic logic [63:0] ref_prod(input int dw, input logic [31:0] a,
                                             input logic [31:0] b, input bit sm);
        longint sa, sb, mask;
        mask = (longint'(1) << dw) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (sm && a[dw-1]) sa = sa - (longint'(1) << dw);
        if (sm && b[dw-1]) sb = sb - (longint'(1) << dw);
        return 64'(sa * sb) & ((64'd1 << (2 * dw)) - 64'd1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: phase = edges since accept; ready exactly at phase DW+3, idle one edge later.
    int          m_phase = 0;
    logic [31:0] m_exp = '0;
    logic [31:0] m_result = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase  <= 0;
            m_result <= '0;
        end else if (bus.sync_clr) begin
            m_phase <= 0;
        end else if (m_phase == 0) begin
            if (bus.start) begin
                m_phase <= 1;
                m_exp   <= 32'(ref_prod(DW, 32'(bus.multiplicand), 32'(bus.multiplier),
                                        bus.signed_mode));
            end
        end else if (m_phase == PH_DONE) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
            if (m_phase + 1 == PH_DONE) m_result <= m_exp;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc busy", 64'(bus.busy), 64'(m_phase != 0));
            chk("cyc ready", 64'(bus.ready), 64'(m_phase == PH_DONE));
            chk("cyc result", 64'(bus.result), 64'(m_result));
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit sm,
                          input logic [31:0] exp, input string nm);
        int lat;
        bit seen;
        bus.multiplicand = a;
        bus.multiplier = b;
        bus.signed_mode = sm;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.multiplicand = ~a;
        bus.multiplier = ~b;
        bus.signed_mode = ~sm;
        lat = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            tick();
            if (bus.ready) begin
                seen = 1'b1;
                lat = i;
            end
        end
        chk({nm, " latency"}, 64'(lat), 64'd18);
        chk({nm, " result"}, 64'(bus.result), 64'(exp));
        tick();
        chk({nm, " idle"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int n_rdy, t1, t2;
        logic [31:0] r1, r2;
        bus.start = 1'b0;
        bus.sync_clr = 1'b0;
        bus.signed_mode = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        tick();
        cmp_en = 1'b1;
        tick();
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset ready", 64'(bus.ready), 64'd0);
        chk("reset result", 64'(bus.result), 64'd0);
        rst = 1'b0;
        tick();

        run_op(16'h0003, 16'hFFFB, 1'b1, 32'hFFFF_FFF1, "s 3x-5");
        run_op(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, "s minxmin");
        run_op(16'hFFFF, 16'h0001, 1'b1, 32'hFFFF_FFFF, "s -1x1");
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, "u maxxmax");
        run_op(16'h0000, 16'h1234, 1'b0, 32'h0000_0000, "u 0x1234");

        // start re-pulsed with new operands while busy
        bus.multiplicand = 16'h0011;
        bus.multiplier = 16'h0013;
        bus.signed_mode = 1'b0;
        bus.start = 1'b1;
        tick();
        n_rdy = 0;
        r1 = '0;
        for (int i = 1; i <= 24; i++) begin
            if (i == 3 || i == 4) begin
                bus.start = 1'b1;
                bus.multiplicand = 16'h7777;
                bus.multiplier = 16'h5555;
                bus.signed_mode = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            if (bus.ready) begin
                n_rdy++;
                r1 = bus.result;
            end
        end
        chk("repulse ready count", 64'(n_rdy), 64'd1);
        chk("repulse result", 64'(r1), 64'h143);

        // start held high: back-to-back operations
        bus.multiplicand = 16'd2;
        bus.multiplier = 16'd3;
        bus.signed_mode = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.multiplicand = 16'd4;
        bus.multiplier = 16'd5;
        t1 = 0;
        t2 = 0;
        r1 = '0;
        r2 = '0;
        for (int t = 1; t <= 38; t++) begin
            tick();
            if (t == 21) bus.start = 1'b0;
            if (bus.ready) begin
                if (t1 == 0) begin
                    t1 = t;
                    r1 = bus.result;
                end else begin
                    t2 = t;
                    r2 = bus.result;
                end
            end
        end
        chk("held first latency", 64'(t1), 64'd18);
        chk("held first result", 64'(r1), 64'd6);
        chk("held second time", 64'(t2), 64'd38);
        chk("held second result", 64'(r2), 64'd20);
        tick();
        chk("held idle", 64'(bus.busy), 64'd0);

        // sync_clr at RUN cycle 5
        bus.multiplicand = 16'd9;
        bus.multiplier = 16'd9;
        bus.signed_mode = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        chk("clr pre busy", 64'(bus.busy), 64'd1);
        bus.sync_clr = 1'b1;
        tick();
        chk("clr busy", 64'(bus.busy), 64'd0);
        chk("clr result kept", 64'(bus.result), 64'd20);
        bus.start = 1'b1;
        tick();
        chk("clr over start", 64'(bus.busy), 64'd0);
        bus.sync_clr = 1'b0;
        bus.start = 1'b0;
        n_rdy = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.ready) n_rdy++;
        end
        chk("clr no ready", 64'(n_rdy), 64'd0);
        chk("clr result after", 64'(bus.result), 64'd20);

        // asynchronous reset at RUN cycle 9
        bus.multiplicand = 16'h0055;
        bus.multiplier = 16'h0066;
        bus.signed_mode = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        chk("rst pre busy", 64'(bus.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst ready", 64'(bus.ready), 64'd0);
        chk("rst result", 64'(bus.result), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_op(16'd7, 16'd6, 1'b1, 32'd42, "post rst 7x6");

        for (int i = 0; i < 60000 && lanes_done < NL; i++) tick();
        chk("lanes finished", 64'(lanes_done), 64'(NL));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int LDW = (g < NL16) ? 16 : 8;
        localparam int NOPS = (g < NL16) ? NOPS16 : NOPS8;

        booth_mult_param_if #(.DW(LDW)) lb ();
        booth_mult_param #(.DW(LDW)) u_dut (.clk(clk), .rst(rst_r), .bus(lb.slave));

        initial begin
            logic [LDW-1:0] a, b;
            logic [63:0]    exp;
            bit             sm;
            bit             seen;
            int             lat;
            lb.start = 1'b0;
            lb.sync_clr = 1'b0;
            lb.signed_mode = 1'b0;
            lb.multiplicand = '0;
            lb.multiplier = '0;
            wait (rst_r == 1'b0);
            tick();
            for (int i = 0; i < NOPS; i++) begin
                a = LDW'($urandom());
                b = LDW'($urandom());
                sm = i[0];
                if (i % 16 == 1) a = {1'b1, {(LDW - 1){1'b0}}};
                if (i % 16 == 2) b = '1;
                lb.multiplicand = a;
                lb.multiplier = b;
                lb.signed_mode = sm;
                lb.start = 1'b1;
                tick();
                lb.start = 1'b0;
                exp = ref_prod(LDW, 32'(a), 32'(b), sm);
                seen = 1'b0;
                lat = 0;
                for (int k = 1; k <= LDW + 4 && !seen; k++) begin
                    tick();
                    if (lb.ready) begin
                        seen = 1'b1;
                        lat = k;
                    end
                end
                chk($sformatf("lane%0d latency", g), 64'(lat), 64'(LDW + 2));
                chk($sformatf("lane%0d result a=%0h b=%0h sm=%0d", g, a, b, sm),
                    64'(lb.result), exp);
                tick();
            end
            lanes_done++;
        end
    end
endmodule

// File: doc/booth_mult_param.md
BOOTH_MULT_PARAM -- requirements
Module: booth_mult_param

Interface
REQ-001 The block SHALL have parameter DW, default 16, giving the operand width in bits; legal range 4..32.
REQ-002 The block SHALL have parameter PW, default 2*DW, giving the product width; PW is not overridable.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port sync_clr, input, 1 bit: synchronous abort; returns the block to IDLE.
REQ-006 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-007 The block SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-008 The block SHALL have port multiplicand, input, DW bits: operand A, sampled with start.
REQ-009 The block SHALL have port multiplier, input, DW bits: operand B, sampled with start.
REQ-010 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-011 The block SHALL have port ready, output, 1 bit: one-cycle pulse in DONE.
REQ-012 The block SHALL have port result, output, PW bits: product, held until the next accepted start.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE when the iteration count reaches DW+1.
- DONE -> IDLE unconditionally.
REQ-014 On accepting start, the block SHALL latch both operands as (DW+1)-bit values.
- Sign-extended when signed_mode=1, zero-extended when signed_mode=0.
- The Booth P register loads {zeros, B_ext, 1'b0}; the iteration counter clears to 0.
REQ-015 Each RUN cycle SHALL perform exactly one radix-2 Booth step on P[1:0]:
- 01: add A_ext to the upper part.
- 10: subtract A_ext (add its two's complement) from the upper part.
- 00 or 11: no add.
- Then arithmetic-shift P right by 1; counter increments.
REQ-016 The add/subtract SHALL be performed at DW+2 bits so no intermediate overflow is lost, including A = most-negative value.
REQ-017 On entering DONE, result SHALL equal the low PW bits of the exact product of the latched operands, interpreted per the latched signed_mode.
REQ-018 Latency SHALL be fixed: start sampled at edge N -> ready high in the cycle after edge N+DW+2 -> busy low after edge N+DW+3.
- Latency is independent of operand values.
REQ-019 start asserted while busy=1 SHALL be ignored and SHALL NOT queue; operand and mode changes during RUN SHALL NOT affect the result.
REQ-020 start SHALL be level-sampled: if held high, a new operation is accepted on the first IDLE cycle after DONE.
REQ-021 sync_clr=1 SHALL force IDLE at the next edge from any state, with the following effects:
- Counter cleared; result unchanged; ready not pulsed.
- sync_clr has priority over start in the same cycle.
REQ-022 ready SHALL never be high for more than one consecutive cycle per operation.

Reset
REQ-023 While rst=1, the block SHALL be in IDLE with busy=0, ready=0, result=0, counter=0 and internal A/P registers=0, independent of clk.
REQ-024 rst asserted mid-RUN SHALL abort the operation with no ready pulse; after rst deasserts, the first start SHALL behave as from power-up.

Verification
REQ-025 The bench SHALL cover these directed scenarios (DW=16):
- signed_mode=1, A=0x0003, B=0xFFFB (-5) -> ready 18 cycles after start, result=0xFFFF_FFF1.
- signed_mode=1, A=B=0x8000 -> result=0x4000_0000; A=0xFFFF, B=0x0001 -> result=0xFFFF_FFFF.
- signed_mode=0, A=B=0xFFFF -> result=0xFFFE_0001; A=0x0000, B=0x1234 -> result=0.
- start re-pulsed with new operands during RUN -> ignored, first result correct, single ready pulse; start held high -> back-to-back operations, each with 18-cycle latency.
- sync_clr at RUN cycle 5 -> busy=0 next cycle, no ready, result keeps the previous value.
- rst at RUN cycle 9 -> all outputs 0 immediately; a following start with A=7, B=6 -> result=42.
REQ-026 The bench SHALL include a randomized self-check of at least 10,000 operand pairs in both modes against a reference model, for DW=16 and DW=8.
